// File: rtl/mem_bus_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : mem_bus_pkg
// Shared encodings for the inst/data memory bus arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Encoding doubles as the bit index into the one-hot grant vector
   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_arb_grant2.sv
//------------------------------------------------------------------------------
// Module : arb_grant2
// Combinational 2-way grant, fixed priority (data first) or round-robin.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arb_grant2
   import mem_bus_pkg::*;
#(
   parameter int RR_MODE = 0
) (
   input  logic [1:0] eligible,
   input  owner_t     lastOwner,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (eligible)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11: begin
            // On contention round-robin hands the port to whoever did not own it last
            if ((RR_MODE != 0) && (lastOwner == OWN_DATA)) begin
               grant = 2'b01;
            end else begin
               grant = 2'b10;
            end
         end
         default: grant = 2'b00;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module : mem_bus_arbiter
// Shares one SRAM-like port between fetch and load/store, one transaction deep.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int RR_MODE = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_except,
   input  logic          inst_req,
   input  logic [AW-1:0] inst_addr,
   output logic          inst_addr_ok,
   output logic          inst_data_ok,
   output logic [DW-1:0] inst_rdata,
   input  logic          data_req,
   input  logic          data_wr,
   input  logic [1:0]    data_size,
   input  logic [AW-1:0] data_addr,
   input  logic [DW-1:0] data_wdata,
   output logic          data_addr_ok,
   output logic          data_data_ok,
   output logic [DW-1:0] data_rdata,
   output logic          req,
   output logic          wr,
   output logic [1:0]    size,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] wdata,
   input  logic          addr_ok,
   input  logic          data_ok,
   input  logic [DW-1:0] rdata,
   output logic          busy
);

   state_t          r_state;
   state_t          w_stateNext;
   owner_t          r_owner;
   owner_t          r_lastOwner;
   logic            r_cancel;
   logic            r_wr;
   logic [1:0]      r_size;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;

   logic [1:0]      w_eligible;
   logic [1:0]      w_grant;
   logic            w_idle;
   logic            w_complete;
   logic            w_grantValid;

   // A flushed fetch must not even be granted
   assign w_eligible   = {data_req, inst_req & ~flush_except};
   assign w_idle       = (r_state == ST_IDLE);
   assign w_grantValid = w_idle & (|w_grant);

   arb_grant2 #(
      .RR_MODE (RR_MODE)
   ) u_grant (
      .eligible  (w_eligible),
      .lastOwner (r_lastOwner),
      .grant     (w_grant)
   );

   assign w_complete = ((r_state == ST_REQ) & addr_ok & data_ok) |
                       ((r_state == ST_WAIT) & data_ok);

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_grantValid) begin
               w_stateNext = ST_REQ;
            end
         end
         ST_REQ: begin
            if (addr_ok) begin
               w_stateNext = data_ok ? ST_IDLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (data_ok) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWN_INST;
         r_lastOwner <= OWN_INST;
         r_cancel    <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         if (w_grantValid) begin
            r_owner     <= w_grant[1] ? OWN_DATA : OWN_INST;
            r_lastOwner <= w_grant[1] ? OWN_DATA : OWN_INST;
         end
         // The slave cannot abort, so a flushed fetch runs on with only its response hidden
         if (w_stateNext == ST_IDLE) begin
            r_cancel <= 1'b0;
         end else if (flush_except && !w_idle && (r_owner == OWN_INST)) begin
            r_cancel <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr    <= 1'b0;
         r_size  <= 2'd0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_grantValid) begin
         if (w_grant[1]) begin
            r_wr    <= data_wr;
            r_size  <= data_size;
            r_addr  <= data_addr;
            r_wdata <= data_wdata;
         end else begin
            r_wr    <= 1'b0;
            r_size  <= SZ_WORD;
            r_addr  <= inst_addr;
            r_wdata <= '0;
         end
      end
   end

   assign inst_addr_ok = w_idle & w_grant[0];
   assign data_addr_ok = w_idle & w_grant[1];

   assign inst_data_ok = w_complete & (r_owner == OWN_INST) & ~r_cancel;
   assign data_data_ok = w_complete & (r_owner == OWN_DATA);

   assign inst_rdata = (!w_idle && (r_owner == OWN_INST)) ? rdata : '0;
   assign data_rdata = (!w_idle && (r_owner == OWN_DATA)) ? rdata : '0;

   assign req   = (r_state == ST_REQ);
   assign wr    = r_wr;
   assign size  = r_size;
   assign addr  = r_addr;
   assign wdata = r_wdata;
   assign busy  = !w_idle;

endmodule

`default_nettype wire
